// File: rtl/ifu_pkg.sv
// Shared types and decode helpers for the decoupled instruction-fetch unit.
package ifu_pkg;

  typedef enum logic {
    ST_REQ,
    ST_MISS
  } state_t;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pnpc;
  } fetch_entry_t;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Redirect, I-cache lookup and decode handshake bundle of the fetch unit.
interface ifu_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          flush;
  logic [31:0]   dnpc;
  logic          fencei;
  logic          cache_fencei;
  logic [31:0]   cache_addr;
  logic          cache_req;
  logic          cache_hit;
  logic [31:0]   cache_inst;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [31:0]   out_pnpc;
  logic [CW-1:0] occupancy;

  modport master (
    input  flush, dnpc, fencei, cache_hit, cache_inst, out_ready,
    output cache_fencei, cache_addr, cache_req, out_valid, out_pc, out_inst, out_pnpc, occupancy
  );

  modport slave (
    output flush, dnpc, fencei, cache_hit, cache_inst, out_ready,
    input  cache_fencei, cache_addr, cache_req, out_valid, out_pc, out_inst, out_pnpc, occupancy
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with registered storage; DEPTH must be a power of 2.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0],
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output T              head
);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push_c;
  logic          do_pop_c;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rptr];
  assign do_push_c = push & ~full & ~clear;
  assign do_pop_c  = pop & ~empty & ~clear;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push_c) wptr <= wptr + AW'(1);
      if (do_pop_c)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  // Payload storage carries no reset; only pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push_c) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Run-ahead fetch stage: static branch prediction, I-cache lookup/miss handling,
// redirect/fence.i handling and a fetch queue toward decode.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter bit          BP_EN    = 1'b1
) (
  input logic               clock,
  input logic               reset,
  ifu_fetch_queue_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   dnpc_r;
  logic          pend;

  logic [31:0]   pnpc_c;
  logic          req_c;
  logic          hit_c;
  logic          push_c;
  logic          pop_c;
  logic          valid_c;
  logic          full_c;
  logic          empty_c;
  logic [CW-1:0] count_c;
  fetch_entry_t  entry_c;
  fetch_entry_t  head_c;

  // Static prediction: backward conditional branches and JAL taken.
  always_comb begin
    pnpc_c = fpc + 32'd4;
    if (BP_EN) begin
      if (bus.cache_inst[6:2] == OP_BRANCH && bus.cache_inst[31]) begin
        pnpc_c = fpc + imm_b(bus.cache_inst);
      end else if (bus.cache_inst[6:2] == OP_JAL) begin
        pnpc_c = fpc + imm_j(bus.cache_inst);
      end
    end
  end

  // A miss keeps requesting the same address; a full queue never issues, even on a pop.
  always_comb begin
    req_c = 1'b0;
    if (!reset && !bus.fencei) begin
      if (state == ST_MISS) req_c = 1'b1;
      else                  req_c = ~full_c & ~bus.flush;
    end
  end

  assign hit_c   = req_c & bus.cache_hit;
  assign push_c  = hit_c & ((state == ST_REQ) | (~pend & ~bus.flush));
  assign valid_c = ~reset & ~empty_c & ~bus.flush & ~pend;
  assign pop_c   = valid_c & bus.out_ready;
  assign entry_c = '{pc: fpc, inst: bus.cache_inst, pnpc: pnpc_c};

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_REQ;
      fpc    <= RESET_PC;
      pend   <= 1'b0;
      dnpc_r <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (bus.flush)  fpc   <= bus.dnpc;
          else if (hit_c) fpc   <= pnpc_c;
          else if (req_c) state <= ST_MISS;
        end
        ST_MISS: begin
          // Redirects during a refill are parked; the latest one wins when the refill lands.
          if (hit_c) begin
            state <= ST_REQ;
            pend  <= 1'b0;
            if (bus.flush)  fpc <= bus.dnpc;
            else if (pend)  fpc <= dnpc_r;
            else            fpc <= pnpc_c;
          end else if (bus.flush) begin
            pend   <= 1'b1;
            dnpc_r <= bus.dnpc;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (entry_c),
    .full  (full_c),
    .empty (empty_c),
    .count (count_c),
    .head  (head_c)
  );

  assign bus.cache_fencei = bus.fencei & ~reset;
  assign bus.cache_addr   = reset ? RESET_PC : fpc;
  assign bus.cache_req    = req_c;
  assign bus.out_valid    = valid_c;
  assign bus.out_pc       = reset ? '0 : head_c.pc;
  assign bus.out_inst     = reset ? '0 : head_c.inst;
  assign bus.out_pnpc     = reset ? '0 : head_c.pnpc;
  assign bus.occupancy    = reset ? '0 : count_c;

`ifndef SYNTHESIS
  logic [31:0] perf_ifu_hold;
  logic [31:0] perf_ifu_wait;
  logic [31:0] perf_ifu_inst;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ifu_hold <= '0;
      perf_ifu_wait <= '0;
      perf_ifu_inst <= '0;
    end else begin
      if (count_c != '0)     perf_ifu_hold <= perf_ifu_hold + 32'd1;
      if (state == ST_MISS)  perf_ifu_wait <= perf_ifu_wait + 32'd1;
      if (pop_c)             perf_ifu_inst <= perf_ifu_inst + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: a predicting and a non-predicting instance
// run in lockstep against a combinational I-cache model.
module tb_ifu_fetch_queue;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] dnpc;
  logic        fencei;
  logic        out_ready;
  logic        miss_active;
  logic [31:0] miss_addr;
  logic        branch_en;

  int checks;
  int errors;

  ifu_fetch_queue_if #(.DEPTH(4)) bus_bp ();
  ifu_fetch_queue_if #(.DEPTH(4)) bus_nbp ();

  ifu_fetch_queue #(.DEPTH(4), .RESET_PC(32'h8000_0000), .BP_EN(1'b1)) dut_bp (
    .clock (clock), .reset (reset), .bus (bus_bp)
  );
  ifu_fetch_queue #(.DEPTH(4), .RESET_PC(32'h8000_0000), .BP_EN(1'b0)) dut_nbp (
    .clock (clock), .reset (reset), .bus (bus_nbp)
  );

  assign bus_bp.flush      = flush;
  assign bus_bp.dnpc       = dnpc;
  assign bus_bp.fencei     = fencei;
  assign bus_bp.out_ready  = out_ready;
  assign bus_nbp.flush     = flush;
  assign bus_nbp.dnpc      = dnpc;
  assign bus_nbp.fencei    = fencei;
  assign bus_nbp.out_ready = out_ready;

  // I-cache model: NOPs everywhere, optional beq x0,x0,-16 at 0x80000010, optional miss address.
  always_comb begin
    bus_bp.cache_hit   = !(miss_active && bus_bp.cache_addr == miss_addr);
    bus_bp.cache_inst  = (branch_en && bus_bp.cache_addr == 32'h8000_0010) ? 32'hFE00_08E3 : 32'h0000_0013;
    bus_nbp.cache_hit  = !(miss_active && bus_nbp.cache_addr == miss_addr);
    bus_nbp.cache_inst = (branch_en && bus_nbp.cache_addr == 32'h8000_0010) ? 32'hFE00_08E3 : 32'h0000_0013;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; fencei = 1'b0; dnpc = '0;
    miss_active = 1'b0; miss_addr = '0; branch_en = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; fencei = 1'b1; dnpc = '0;
    miss_active = 1'b0; miss_addr = '0; branch_en = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clock);
    checks++; if (bus_bp.cache_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got %h exp %h", bus_bp.cache_addr, 32'h8000_0000); end
    checks++; if (bus_bp.cache_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus_bp.cache_req); end
    checks++; if (bus_bp.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus_bp.out_valid); end
    checks++; if (bus_bp.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", bus_bp.occupancy); end
    checks++; if (bus_bp.cache_fencei !== 1'b0) begin errors++; $display("FAIL reset_fencei got %b exp 0", bus_bp.cache_fencei); end
    fencei = 1'b0;
  endtask

  task automatic test_straight();
    logic [31:0] exp;
    do_reset();
    @(negedge clock);
    checks++; if (bus_bp.out_valid !== 1'b0) begin errors++; $display("FAIL straight_c1_valid got %b exp 0", bus_bp.out_valid); end
    checks++; if (bus_bp.cache_req !== 1'b1) begin errors++; $display("FAIL straight_c1_req got %b exp 1", bus_bp.cache_req); end
    checks++; if (bus_bp.cache_addr !== 32'h8000_0000) begin errors++; $display("FAIL straight_c1_addr got %h exp %h", bus_bp.cache_addr, 32'h8000_0000); end
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clock);
      exp = 32'h8000_0000 + 32'(4 * k);
      checks++; if (bus_bp.out_valid !== 1'b1) begin errors++; $display("FAIL straight_valid k=%0d got %b exp 1", k, bus_bp.out_valid); end
      checks++; if (bus_bp.out_pc !== exp) begin errors++; $display("FAIL straight_pc k=%0d got %h exp %h", k, bus_bp.out_pc, exp); end
      checks++; if (bus_bp.out_pnpc !== exp + 32'd4) begin errors++; $display("FAIL straight_pnpc k=%0d got %h exp %h", k, bus_bp.out_pnpc, exp + 32'd4); end
      checks++; if (bus_bp.out_inst !== 32'h0000_0013) begin errors++; $display("FAIL straight_inst k=%0d got %h exp 00000013", k, bus_bp.out_inst); end
      checks++; if (bus_bp.occupancy !== 3'd1) begin errors++; $display("FAIL straight_occ k=%0d got %0d exp 1", k, bus_bp.occupancy); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    do_reset();
    out_ready = 1'b0;
    repeat (6) cyc();
    @(negedge clock);
    checks++; if (bus_bp.occupancy !== 3'd4) begin errors++; $display("FAIL bp_full_occ got %0d exp 4", bus_bp.occupancy); end
    checks++; if (bus_bp.cache_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b exp 0", bus_bp.cache_req); end
    checks++; if (bus_bp.out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid got %b exp 1", bus_bp.out_valid); end
    checks++; if (bus_bp.out_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_hold_pc got %h exp %h", bus_bp.out_pc, 32'h8000_0000); end
    checks++; if (bus_bp.cache_addr !== 32'h8000_0010) begin errors++; $display("FAIL bp_full_addr got %h exp %h", bus_bp.cache_addr, 32'h8000_0010); end
    cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      exp = 32'h8000_0000 + 32'(4 * k);
      checks++; if (bus_bp.out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid k=%0d got %b exp 1", k, bus_bp.out_valid); end
      checks++; if (bus_bp.out_pc !== exp) begin errors++; $display("FAIL bp_drain_pc k=%0d got %h exp %h", k, bus_bp.out_pc, exp); end
      cyc();
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_bp  [7];
    logic [31:0] exp_nbp [7];
    exp_bp  = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0010, 32'h8000_0000, 32'h8000_0004};
    exp_nbp = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0010, 32'h8000_0014, 32'h8000_0018};
    do_reset();
    branch_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      @(negedge clock);
      checks++; if (bus_bp.out_pc !== exp_bp[k]) begin errors++; $display("FAIL branch_bp_pc k=%0d got %h exp %h", k, bus_bp.out_pc, exp_bp[k]); end
      checks++; if (bus_nbp.out_pc !== exp_nbp[k]) begin errors++; $display("FAIL branch_nbp_pc k=%0d got %h exp %h", k, bus_nbp.out_pc, exp_nbp[k]); end
      if (k == 4) begin
        checks++; if (bus_bp.out_inst !== 32'hFE00_08E3) begin errors++; $display("FAIL branch_inst got %h exp FE0008E3", bus_bp.out_inst); end
        checks++; if (bus_bp.out_pnpc !== 32'h8000_0000) begin errors++; $display("FAIL branch_bp_pnpc got %h exp 80000000", bus_bp.out_pnpc); end
        checks++; if (bus_nbp.out_pnpc !== 32'h8000_0014) begin errors++; $display("FAIL branch_nbp_pnpc got %h exp 80000014", bus_nbp.out_pnpc); end
        checks++; if (bus_bp.cache_addr !== 32'h8000_0000) begin errors++; $display("FAIL branch_bp_addr got %h exp 80000000", bus_bp.cache_addr); end
        checks++; if (bus_nbp.cache_addr !== 32'h8000_0014) begin errors++; $display("FAIL branch_nbp_addr got %h exp 80000014", bus_nbp.cache_addr); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    repeat (3) cyc();
    flush = 1'b1;
    dnpc  = 32'h8000_0100;
    @(negedge clock);
    checks++; if (bus_bp.occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got %0d exp 3", bus_bp.occupancy); end
    checks++; if (bus_bp.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus_bp.out_valid); end
    checks++; if (bus_bp.cache_req !== 1'b0) begin errors++; $display("FAIL flush_req got %b exp 0", bus_bp.cache_req); end
    cyc();
    flush = 1'b0;
    @(negedge clock);
    checks++; if (bus_bp.occupancy !== 3'd0) begin errors++; $display("FAIL flush_post_occ got %0d exp 0", bus_bp.occupancy); end
    checks++; if (bus_bp.cache_addr !== 32'h8000_0100) begin errors++; $display("FAIL flush_post_addr got %h exp 80000100", bus_bp.cache_addr); end
    checks++; if (bus_bp.cache_req !== 1'b1) begin errors++; $display("FAIL flush_post_req got %b exp 1", bus_bp.cache_req); end
  endtask

  task automatic test_fencei();
    do_reset();
    repeat (2) cyc();
    fencei = 1'b1;
    flush  = 1'b1;
    dnpc   = 32'h8000_0040;
    @(negedge clock);
    checks++; if (bus_bp.cache_fencei !== 1'b1) begin errors++; $display("FAIL fencei_fwd got %b exp 1", bus_bp.cache_fencei); end
    checks++; if (bus_bp.cache_req !== 1'b0) begin errors++; $display("FAIL fencei_req got %b exp 0", bus_bp.cache_req); end
    cyc();
    fencei = 1'b0;
    flush  = 1'b0;
    @(negedge clock);
    checks++; if (bus_bp.cache_fencei !== 1'b0) begin errors++; $display("FAIL fencei_clear got %b exp 0", bus_bp.cache_fencei); end
    checks++; if (bus_bp.cache_addr !== 32'h8000_0040) begin errors++; $display("FAIL fencei_addr got %h exp 80000040", bus_bp.cache_addr); end
    cyc();
    @(negedge clock);
    checks++; if (bus_bp.out_pc !== 32'h8000_0040) begin errors++; $display("FAIL fencei_pc got %h exp 80000040", bus_bp.out_pc); end
  endtask

  task automatic seek_miss(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (bus_bp.cache_addr == 32'h8000_0020) found = 1'b1;
      else cyc();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL miss_reach got timeout exp addr 80000020"); end
  endtask

  task automatic test_miss_redirect();
    bit found;
    do_reset();
    miss_addr   = 32'h8000_0020;
    miss_active = 1'b1;
    seek_miss(found);
    if (found) begin
      for (int i = 0; i < 10; i++) begin
        cyc();
        flush = (i == 2 || i == 5);
        dnpc  = (i == 2) ? 32'h8000_0200 : 32'h8000_0300;
        if (i == 9) miss_active = 1'b0;
        @(negedge clock);
        checks++; if (bus_bp.cache_addr !== 32'h8000_0020) begin errors++; $display("FAIL miss_addr i=%0d got %h exp 80000020", i, bus_bp.cache_addr); end
        checks++; if (bus_bp.cache_req !== 1'b1) begin errors++; $display("FAIL miss_req i=%0d got %b exp 1", i, bus_bp.cache_req); end
        if (i >= 2) begin
          checks++; if (bus_bp.out_valid !== 1'b0) begin errors++; $display("FAIL miss_valid i=%0d got %b exp 0", i, bus_bp.out_valid); end
        end
      end
      cyc();
      flush = 1'b0;
      @(negedge clock);
      checks++; if (bus_bp.cache_addr !== 32'h8000_0300) begin errors++; $display("FAIL miss_resume_addr got %h exp 80000300", bus_bp.cache_addr); end
      checks++; if (bus_bp.out_valid !== 1'b0) begin errors++; $display("FAIL miss_discard_valid got %b exp 0", bus_bp.out_valid); end
      cyc();
      @(negedge clock);
      checks++; if (bus_bp.out_valid !== 1'b1) begin errors++; $display("FAIL miss_resume_valid got %b exp 1", bus_bp.out_valid); end
      checks++; if (bus_bp.out_pc !== 32'h8000_0300) begin errors++; $display("FAIL miss_resume_pc got %h exp 80000300", bus_bp.out_pc); end
    end
  endtask

  task automatic test_reset_mid_miss();
    bit found;
    logic [31:0] exp;
    do_reset();
    miss_addr   = 32'h8000_0020;
    miss_active = 1'b1;
    seek_miss(found);
    if (found) begin
      repeat (3) cyc();
      reset = 1'b1;
      @(negedge clock);
      checks++; if (bus_bp.cache_addr !== 32'h8000_0000) begin errors++; $display("FAIL rmm_addr got %h exp 80000000", bus_bp.cache_addr); end
      checks++; if (bus_bp.cache_req !== 1'b0) begin errors++; $display("FAIL rmm_req got %b exp 0", bus_bp.cache_req); end
      cyc();
      reset       = 1'b0;
      miss_active = 1'b0;
      @(negedge clock);
      checks++; if (bus_bp.occupancy !== 3'd0) begin errors++; $display("FAIL rmm_occ got %0d exp 0", bus_bp.occupancy); end
      checks++; if (bus_bp.out_valid !== 1'b0) begin errors++; $display("FAIL rmm_valid got %b exp 0", bus_bp.out_valid); end
      checks++; if (bus_bp.cache_addr !== 32'h8000_0000) begin errors++; $display("FAIL rmm_restart got %h exp 80000000", bus_bp.cache_addr); end
      checks++; if (bus_bp.cache_req !== 1'b1) begin errors++; $display("FAIL rmm_restart_req got %b exp 1", bus_bp.cache_req); end
      for (int k = 0; k < 3; k++) begin
        cyc();
        @(negedge clock);
        exp = 32'h8000_0000 + 32'(4 * k);
        checks++; if (bus_bp.out_pc !== exp) begin errors++; $display("FAIL rmm_pc k=%0d got %h exp %h", k, bus_bp.out_pc, exp); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_straight();
    test_backpressure();
    test_branch();
    test_flush();
    test_fencei();
    test_miss_redirect();
    test_reset_mid_miss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
